// File: rtl/ram_pkg.sv
`default_nettype none
// ==== ram_pkg : shared constants, state type and sizing helpers for ram_sdp_param (rev 1.0) ====
package ram_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic [0:0] {
      RAM_INIT = 1'b0,
      RAM_RUN  = 1'b1
   } ram_state_t;

   function automatic int lane_count(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_init_ctrl.sv
`default_nettype none
// ==== ram_init_ctrl : post-reset zero-clear sweep FSM for ram_sdp_param (rev 1.0) ====
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_W         = 6,
   parameter int DEPTH          = 64,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              init_busy
);

   generate
      if (CLEAR_ON_RESET != 0) begin : g_clear
         localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

         ram_state_t        state_q, state_d;
         logic [ADDR_W-1:0] cnt_q, cnt_d;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= RAM_INIT;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         // The edge that clears the last word also leaves INIT.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (state_q == RAM_INIT) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_d = RAM_RUN;
                  cnt_d   = '0;
               end
            end
         end

         assign clr_we    = (state_q == RAM_INIT);
         assign clr_addr  = cnt_q;
         assign init_busy = (state_q == RAM_INIT);
      end else begin : g_no_clear
         assign clr_we    = 1'b0;
         assign clr_addr  = '0;
         assign init_busy = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ram_sdp_param.sv
`default_nettype none
// ==== ram_sdp_param : parametrised simple-dual-port RAM, byte lanes, RDW policy, optional out reg (rev 1.0) ====
module ram_sdp_param
   import ram_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int BYTE_W         = 8,
   parameter int ADDR_W         = 6,
   parameter int DEPTH          = 64,
   parameter int RDW_MODE       = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [DATA_W/BYTE_W-1:0] be,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     re,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     init_busy
);

   localparam int                NB      = lane_count(DATA_W, BYTE_W);
   localparam int                IDX_W   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   generate
      if (DATA_W % BYTE_W != 0) begin : g_bad_lanes
         $error("ram_sdp_param: DATA_W must be a multiple of BYTE_W");
      end
      if (clog2(DEPTH) > ADDR_W) begin : g_bad_depth
         $error("ram_sdp_param: DEPTH exceeds 2**ADDR_W");
      end
   endgenerate

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_in_range, rd_in_range;
   logic              user_we, rd_fire, wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] user_mask, wr_mask, wr_word, rd_old, rd_word;
   logic [DATA_W-1:0] mem [DEPTH];

   ram_init_ctrl #(
      .ADDR_W         (ADDR_W),
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_init_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_busy (init_busy)
   );

   always_comb begin
      wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
      rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
      user_we     = we & ~init_busy & wr_in_range;
      rd_fire     = re & ~init_busy;
      wr_en       = clr_we | user_we;
      wr_idx      = clr_we ? clr_addr : wr_addr;
      wr_word     = clr_we ? '0 : wr_data;
      user_mask   = '0;
      for (int i = 0; i < NB; i++) begin
         user_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
      end
      wr_mask = clr_we ? '1 : user_mask;
   end

   // Write-first forwarding merges the incoming lanes over the old word.
   always_comb begin
      rd_old  = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
      rd_word = rd_old;
      if (RDW_MODE == RDW_NEW && user_we && wr_addr == rd_addr) begin
         rd_word = (rd_old & ~user_mask) | (wr_data & user_mask);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx[IDX_W-1:0]] <= (mem[wr_idx[IDX_W-1:0]] & ~wr_mask) | (wr_word & wr_mask);
      end
   end

   logic              rd_valid1_q, rd_valid1_d;
   logic [DATA_W-1:0] rd_data1_q, rd_data1_d;

   always_comb begin
      rd_valid1_d = rd_fire;
      rd_data1_d  = rd_fire ? rd_word : rd_data1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid1_q <= 1'b0;
         rd_data1_q  <= '0;
      end else begin
         rd_valid1_q <= rd_valid1_d;
         rd_data1_q  <= rd_data1_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              rd_valid2_q, rd_valid2_d;
         logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

         always_comb begin
            rd_valid2_d = rd_valid1_q;
            rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_valid2_q <= 1'b0;
               rd_data2_q  <= '0;
            end else begin
               rd_valid2_q <= rd_valid2_d;
               rd_data2_q  <= rd_data2_d;
            end
         end

         assign rd_data  = rd_data2_q;
         assign rd_valid = rd_valid2_q;
      end else begin : g_no_out_reg
         assign rd_data  = rd_data1_q;
         assign rd_valid = rd_valid1_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_param.sv
`default_nettype none
// ==== tb_ram_sdp_param : directed self-checking bench, four configurations on shared stimulus (rev 1.0) ====
module tb_ram_sdp_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [1:0]  be;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic        re;
   logic [5:0]  rd_addr;
   logic [15:0] rd_data_o  [4];
   logic        rd_valid_o [4];
   logic        init_busy_o[4];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // 0: defaults, 1: write-first, 2: output register, 3: DEPTH 48
   ram_sdp_param u_d0 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .wr_data(wr_data),
      .re(re), .rd_addr(rd_addr), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
      .init_busy(init_busy_o[0]));
   ram_sdp_param #(.RDW_MODE(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .wr_data(wr_data),
      .re(re), .rd_addr(rd_addr), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
      .init_busy(init_busy_o[1]));
   ram_sdp_param #(.OUT_REG(1)) u_d2 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .wr_data(wr_data),
      .re(re), .rd_addr(rd_addr), .rd_data(rd_data_o[2]), .rd_valid(rd_valid_o[2]),
      .init_busy(init_busy_o[2]));
   ram_sdp_param #(.DEPTH(48)) u_d3 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .wr_data(wr_data),
      .re(re), .rd_addr(rd_addr), .rd_data(rd_data_o[3]), .rd_valid(rd_valid_o[3]),
      .init_busy(init_busy_o[3]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
      we = 1'b1; wr_addr = a; wr_data = d; be = b;
      tick();
      we = 1'b0;
   endtask

   task automatic rd1(input logic [5:0] a);
      re = 1'b1; rd_addr = a;
      tick();
      re = 1'b0;
   endtask

   task automatic measure_sweep(output int busy0, output int busy3, output logic saw_valid);
      busy0 = 0; busy3 = 0; saw_valid = 1'b0;
      for (int k = 0; k < 200 && init_busy_o[0]; k++) begin
         busy0++;
         if (init_busy_o[3]) busy3++;
         if (rd_valid_o[0] | rd_valid_o[1] | rd_valid_o[2] | (init_busy_o[3] & rd_valid_o[3]))
            saw_valid = 1'b1;
         tick();
      end
   endtask

   int   b0, b3;
   logic sv;

   initial begin
      rst_n = 1'b0; we = 1'b0; be = 2'b00; wr_addr = '0; wr_data = '0; re = 1'b0; rd_addr = '0;
      repeat (3) tick();

      check_eq("reset_rd_valid", rd_valid_o[0], 1'b0);
      check_eq("reset_rd_data", rd_data_o[0], 16'h0000);
      check_eq("reset_init_busy", init_busy_o[0], 1'b1);
      check_eq("reset_rd_data_outreg", rd_data_o[2], 16'h0000);

      // Clear sweep with a read held on address 5
      re = 1'b1; rd_addr = 6'h05;
      rst_n = 1'b1;
      measure_sweep(b0, b3, sv);
      re = 1'b0;
      check_eq("sweep_busy_cycles", b0, 64);
      check_eq("sweep_busy_cycles_d48", b3, 48);
      check_eq("sweep_no_rd_valid", sv, 1'b0);

      rd1(6'h00);
      check_eq("clear_rd_00", rd_data_o[0], 16'h0000);
      check_eq("clear_valid_00", rd_valid_o[0], 1'b1);
      rd1(6'h05);
      check_eq("clear_rd_05", rd_data_o[0], 16'h0000);
      rd1(6'h3F);
      check_eq("clear_rd_3f", rd_data_o[0], 16'h0000);
      tick();
      check_eq("idle_rd_valid", rd_valid_o[0], 1'b0);

      // Byte enables
      wr(6'h01, 16'hAABB, 2'b11);
      wr(6'h01, 16'hCCDD, 2'b01);
      check_eq("be_pre_valid", rd_valid_o[0], 1'b0);
      rd1(6'h01);
      check_eq("be_merge_data", rd_data_o[0], 16'hAADD);
      check_eq("be_valid_1cyc", rd_valid_o[0], 1'b1);
      tick();
      check_eq("be_valid_drop", rd_valid_o[0], 1'b0);
      check_eq("be_data_hold", rd_data_o[0], 16'hAADD);

      // Read-during-write on the same address
      wr(6'h03, 16'h1234, 2'b11);
      we = 1'b1; wr_addr = 6'h03; wr_data = 16'h5678; be = 2'b11;
      re = 1'b1; rd_addr = 6'h03;
      tick();
      we = 1'b0; re = 1'b0;
      check_eq("rdw_old", rd_data_o[0], 16'h1234);
      check_eq("rdw_new", rd_data_o[1], 16'h5678);
      rd1(6'h03);
      check_eq("rdw_after_old", rd_data_o[0], 16'h5678);
      check_eq("rdw_after_new", rd_data_o[1], 16'h5678);
      we = 1'b1; wr_addr = 6'h03; wr_data = 16'h9999; be = 2'b01;
      re = 1'b1; rd_addr = 6'h03;
      tick();
      we = 1'b0; re = 1'b0;
      check_eq("rdw_partial_old", rd_data_o[0], 16'h5678);
      check_eq("rdw_partial_new", rd_data_o[1], 16'h5699);

      // Streaming reads through the output register
      for (int i = 0; i < 4; i++) wr(6'h10 + 6'(i), 16'h0100 + 16'(i), 2'b11);
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            re = 1'b1; rd_addr = 6'h10 + 6'(k);
         end else begin
            re = 1'b0;
         end
         tick();
         if (k < 4) begin
            check_eq($sformatf("stream_d0_data_%0d", k), rd_data_o[0], 16'h0100 + 16'(k));
            check_eq($sformatf("stream_d0_valid_%0d", k), rd_valid_o[0], 1'b1);
         end
         if (k == 0 || k == 5) begin
            check_eq($sformatf("stream_oreg_valid_lo_%0d", k), rd_valid_o[2], 1'b0);
         end else begin
            check_eq($sformatf("stream_oreg_valid_%0d", k), rd_valid_o[2], 1'b1);
            check_eq($sformatf("stream_oreg_data_%0d", k), rd_data_o[2], 16'h0100 + 16'(k - 1));
         end
      end

      // Out-of-range on the 48-deep instance
      wr(6'h2F, 16'h1357, 2'b11);
      wr(6'h30, 16'hFFFF, 2'b11);
      rd1(6'h2F);
      check_eq("oor_pre_2f", rd_data_o[3], 16'h1357);
      rd1(6'h30);
      check_eq("oor_rd_data", rd_data_o[3], 16'h0000);
      check_eq("oor_rd_valid", rd_valid_o[3], 1'b1);
      check_eq("inrange_d0_30", rd_data_o[0], 16'hFFFF);
      rd1(6'h2F);
      check_eq("oor_2f_kept", rd_data_o[3], 16'h1357);

      // Reset mid-sweep
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check_eq("midsweep_busy", init_busy_o[0], 1'b1);
      rst_n = 1'b0;
      repeat (2) tick();
      check_eq("midsweep_reset_valid", rd_valid_o[0], 1'b0);
      rst_n = 1'b1;
      measure_sweep(b0, b3, sv);
      check_eq("resweep_busy_cycles", b0, 64);
      check_eq("resweep_busy_cycles_d48", b3, 48);
      for (int a = 0; a < 64; a++) begin
         re = 1'b1; rd_addr = 6'(a);
         tick();
         check_eq($sformatf("resweep_rd_%02h", a), {rd_valid_o[0], rd_data_o[0]}, {1'b1, 16'h0000});
      end
      re = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
